log_operand_feeder: RTL

- Driver and consumer end of the Log unit interface in the Box-Muller AWGN datapath.
- Accepts 48-bit uniform samples u0 from the URNG over a valid/ready handshake and computes the leading-zero count (LZD_Log) that Log needs.
- Presents u0 and LZD_Log to Log, serves Log's 8-bit coefficient index x_e_A from a 256x65 coefficient table, and collects Log's result e with a matching valid flag.

---
 rtl/log_fe_pkg.sv | 24 ++
 rtl/log_operand_feeder_lzd48.sv | 26 ++
 rtl/log_operand_feeder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/log_fe_pkg.sv
// Shared widths, constants and the coefficient word layout for the Log operand feeder.
package log_fe_pkg;

  localparam int unsigned U0_W   = 48;
  localparam int unsigned LZD_W  = 6;
  localparam int unsigned COEF_W = 65;
  localparam int unsigned E_W    = 31;
  localparam int unsigned IDX_W  = 8;

  // Coefficient field widths: c2[64:52], c1[51:30], c0[29:0]
  localparam int unsigned C2_W = 13;
  localparam int unsigned C1_W = 22;
  localparam int unsigned C0_W = 30;

  localparam logic [E_W-1:0]   E_SAT_VAL = 31'h7FFF_FFFF;
  localparam logic [LZD_W-1:0] LZD_ZERO  = 6'd47;

  typedef struct packed {
    logic [C2_W-1:0] c2;
    logic [C1_W-1:0] c1;
    logic [C0_W-1:0] c0;
  } coef_t;

endpackage

// File: rtl/log_operand_feeder_lzd48.sv
// Combinational 48-bit leading-zero counter; an all-zero input reports 47 plus is_zero.
module lzd48
  import log_fe_pkg::*;
(
  input  logic [U0_W-1:0]  v_i,
  output logic [LZD_W-1:0] cnt_o,
  output logic             zero_o
);

  logic found;

  // Scan from the MSB; the first set bit fixes the count.
  always_comb begin
    cnt_o = LZD_ZERO;
    found = 1'b0;
    for (int i = U0_W - 1; i >= 0; i--) begin
      if (!found && v_i[i]) begin
        cnt_o = LZD_W'(U0_W - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign zero_o = ~|v_i;

endmodule

// File: rtl/log_operand_feeder.sv
// Feeds u0/LZD_Log to the Log unit, serves its coefficient lookups and captures its result
// after a fixed pipeline latency, saturating the result for zero samples.
module log_operand_feeder
  import log_fe_pkg::*;
#(
  parameter int unsigned LOG_LAT   = 9,
  parameter int unsigned TBL_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [U0_W-1:0]   u0_in,
  input  logic              u0_valid,
  output logic              u0_ready,
  input  logic              coeff_we,
  input  logic [IDX_W-1:0]  coeff_waddr,
  input  logic [COEF_W-1:0] coeff_wdata,
  output logic [U0_W-1:0]   u0,
  output logic [LZD_W-1:0]  LZD_Log,
  input  logic [IDX_W-1:0]  x_e_A,
  output logic [COEF_W-1:0] coeffs_Log_in,
  input  logic [E_W-1:0]    e,
  output logic [E_W-1:0]    e_out,
  output logic              e_valid,
  output logic              e_sat,
  output logic              tbl_loaded
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               loaded_q, loaded_d;
  logic [U0_W-1:0]    u0_q, u0_d;
  logic [LZD_W-1:0]   lzd_q, lzd_d;
  logic [LOG_LAT-1:0] vld_q, vld_d, sat_q, sat_d;
  logic [E_W-1:0]     eout_q, eout_d;
  logic               evld_q, evld_d;
  logic               esat_q, esat_d;
  coef_t              coef_q;
  coef_t              tbl_mem [TBL_DEPTH];

  logic [LZD_W-1:0]   lzd_cnt;
  logic               lzd_zero;
  logic               xfer;

  lzd48 u_lzd (
    .v_i    (u0_in),
    .cnt_o  (lzd_cnt),
    .zero_o (lzd_zero)
  );

  assign u0_ready = loaded_q & ~coeff_we;
  assign xfer     = u0_valid & u0_ready;

  always_comb begin
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    u0_d     = u0_q;
    lzd_d    = lzd_q;
    eout_d   = eout_q;
    esat_d   = esat_q;
    evld_d   = 1'b0;
    vld_d    = {vld_q[LOG_LAT-2:0], xfer};
    sat_d    = {sat_q[LOG_LAT-2:0], xfer & lzd_zero};

    // Load counter saturates at the table depth; loaded is sticky until reset.
    if (coeff_we && (cnt_q != CNT_W'(TBL_DEPTH))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_d == CNT_W'(TBL_DEPTH)) begin
      loaded_d = 1'b1;
    end

    if (xfer) begin
      u0_d  = u0_in;
      lzd_d = lzd_cnt;
    end

    // Capture Log's result when the oldest pipeline slot holds a live sample.
    if (vld_q[LOG_LAT-1]) begin
      evld_d = 1'b1;
      esat_d = sat_q[LOG_LAT-1];
      eout_d = sat_q[LOG_LAT-1] ? E_SAT_VAL : e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      u0_q     <= '0;
      lzd_q    <= '0;
      vld_q    <= '0;
      sat_q    <= '0;
      eout_q   <= '0;
      evld_q   <= 1'b0;
      esat_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      u0_q     <= u0_d;
      lzd_q    <= lzd_d;
      vld_q    <= vld_d;
      sat_q    <= sat_d;
      eout_q   <= eout_d;
      evld_q   <= evld_d;
      esat_q   <= esat_d;
    end
  end

  // Table storage is not reset; a same-address write returns the old word this cycle.
  always_ff @(posedge clk) begin
    if (coeff_we) begin
      tbl_mem[coeff_waddr] <= coef_t'(coeff_wdata);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_q <= '0;
    end else begin
      coef_q <= tbl_mem[x_e_A];
    end
  end

  assign u0            = u0_q;
  assign LZD_Log       = lzd_q;
  assign coeffs_Log_in = COEF_W'(coef_q);
  assign e_out         = eout_q;
  assign e_valid       = evld_q;
  assign e_sat         = esat_q;
  assign tbl_loaded    = loaded_q;

endmodule
